// File: rtl/fifo_ptr_ctrl_6b.sv
// Read/write pointer controller for a 2^(PTR_W-1)-entry FIFO: pointers, occupancy,
// registered status flags, combinational accepts and sticky overflow/underflow.
module fifo_ptr_ctrl_6b #(
    parameter int unsigned PTR_W     = 6,
    parameter int unsigned AF_THRESH = 28,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             WriteReq,
    input  logic             ReadReq,
    output logic             WrAccept,
    output logic             RdAccept,
    output logic [PTR_W-2:0] WrAddr,
    output logic [PTR_W-2:0] RdAddr,
    output logic [PTR_W-1:0] Count,
    output logic             Full,
    output logic             Empty,
    output logic             AlmostFull,
    output logic             AlmostEmpty,
    output logic             Overflow,
    output logic             Underflow
);

    localparam int unsigned     AW     = PTR_W - 1;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_sel, rd_ptr_sel;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
    logic [PTR_W-1:0] count_next;
    logic             full_next, empty_next;
    logic             af_next, ae_next;
    logic             ovf_next, udf_next;

    // 2:1 hold/increment select feeding each pointer register
    function automatic logic [PTR_W-1:0] hold_inc(input logic [PTR_W-1:0] ptr,
                                                  input logic             sel);
        logic [PTR_W-1:0] inc;
        inc = ptr + PTR_W'(1);
        return sel ? inc : ptr;
    endfunction

    always_comb begin
        WrAccept = WriteReq & ~Full  & ~Clear;
        RdAccept = ReadReq  & ~Empty & ~Clear;
    end

    always_comb begin
        WrAddr = wr_ptr[AW-1:0];
        RdAddr = rd_ptr[AW-1:0];
    end

    always_comb begin
        wr_ptr_sel  = hold_inc(wr_ptr, WrAccept);
        rd_ptr_sel  = hold_inc(rd_ptr, RdAccept);
        wr_ptr_next = Clear ? '0 : wr_ptr_sel;
        rd_ptr_next = Clear ? '0 : rd_ptr_sel;
    end

    // Status derives from the next pointers so the registered flags carry no lag
    always_comb begin
        count_next = wr_ptr_next - rd_ptr_next;
        full_next  = (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &
                     (wr_ptr_next[AW] != rd_ptr_next[AW]);
        empty_next = (wr_ptr_next == rd_ptr_next);
        af_next    = (count_next >= AF_LVL);
        ae_next    = (count_next <= AE_LVL);
    end

    always_comb begin
        ovf_next = ~Clear & (Overflow  | (WriteReq & Full));
        udf_next = ~Clear & (Underflow | (ReadReq  & Empty));
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Count       <= '0;
            Full        <= 1'b0;
            Empty       <= 1'b1;
            AlmostFull  <= 1'b0;
            AlmostEmpty <= 1'b1;
        end else begin
            Count       <= count_next;
            Full        <= full_next;
            Empty       <= empty_next;
            AlmostFull  <= af_next;
            AlmostEmpty <= ae_next;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Overflow  <= ovf_next;
            Underflow <= udf_next;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl_6b.sv
// Self-checking bench for fifo_ptr_ctrl_6b: occupancy model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_ptr_ctrl_6b;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Clear = 1'b0;
    logic       WriteReq = 1'b0;
    logic       ReadReq = 1'b0;
    logic       WrAccept, RdAccept;
    logic [4:0] WrAddr, RdAddr;
    logic [5:0] Count;
    logic       Full, Empty, AlmostFull, AlmostEmpty, Overflow, Underflow;

    fifo_ptr_ctrl_6b #(.PTR_W(6), .AF_THRESH(28), .AE_THRESH(4)) dut (
        .Clock(Clock), .Reset(Reset), .Clear(Clear),
        .WriteReq(WriteReq), .ReadReq(ReadReq),
        .WrAccept(WrAccept), .RdAccept(RdAccept),
        .WrAddr(WrAddr), .RdAddr(RdAddr), .Count(Count),
        .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clock = ~Clock;

    int n_pass = 0;
    int n_total = 0;
    bit en_cmp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: occupancy as an integer, pointers as free-running counters mod 64
    int m_cnt = 0, m_wr = 0, m_rd = 0;
    bit m_ovf = 0, m_udf = 0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset || Clear) begin
            m_cnt <= 0; m_wr <= 0; m_rd <= 0; m_ovf <= 0; m_udf <= 0;
        end else begin
            m_wr  <= (WriteReq && m_cnt < 32) ? (m_wr + 1) % 64 : m_wr;
            m_rd  <= (ReadReq  && m_cnt > 0)  ? (m_rd + 1) % 64 : m_rd;
            m_cnt <= m_cnt + ((WriteReq && m_cnt < 32) ? 1 : 0)
                           - ((ReadReq  && m_cnt > 0)  ? 1 : 0);
            m_ovf <= m_ovf || (WriteReq && m_cnt == 32);
            m_udf <= m_udf || (ReadReq  && m_cnt == 0);
        end
    end

    always @(negedge Clock) begin
        if (en_cmp) begin
            check("wr_accept", WrAccept, (WriteReq && !Clear && m_cnt != 32) ? 1 : 0);
            check("rd_accept", RdAccept, (ReadReq  && !Clear && m_cnt != 0)  ? 1 : 0);
            check("wr_addr", WrAddr, m_wr % 32);
            check("rd_addr", RdAddr, m_rd % 32);
            check("count", Count, m_cnt);
            check("full", Full, (m_cnt == 32) ? 1 : 0);
            check("empty", Empty, (m_cnt == 0) ? 1 : 0);
            check("almost_full", AlmostFull, (m_cnt >= 28) ? 1 : 0);
            check("almost_empty", AlmostEmpty, (m_cnt <= 4) ? 1 : 0);
            check("overflow", Overflow, m_ovf);
            check("underflow", Underflow, m_udf);
        end
    end

    // Inputs are applied 1 time unit after a rising edge; drive() leaves us 2 after it
    task automatic drive(input bit w, input bit r, input bit c);
        WriteReq = w; ReadReq = r; Clear = c;
        #1;
    endtask

    task automatic edge_step();
        @(posedge Clock);
        #1;
    endtask

    int wraps;
    int prev_wr;

    initial begin
        #1 Reset = 1'b1;
        en_cmp = 1'b1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;

        check("rst_count", Count, 0);
        check("rst_empty", Empty, 1);
        check("rst_ae", AlmostEmpty, 1);
        check("rst_full", Full, 0);
        check("rst_af", AlmostFull, 0);
        check("rst_ovf", Overflow, 0);

        // Read on empty FIFO
        drive(0, 1, 0);
        check("udf_rdaccept", RdAccept, 0);
        edge_step();
        check("udf_flag", Underflow, 1);
        check("udf_rdaddr", RdAddr, 0);
        check("udf_empty", Empty, 1);

        // Build WrPtr=7, Count=5, then reset mid-burst
        drive(0, 0, 0);
        for (int i = 0; i < 5; i++) begin drive(1, 0, 0); edge_step(); end
        for (int i = 0; i < 2; i++) begin drive(1, 1, 0); edge_step(); end
        check("burst_count", Count, 5);
        check("burst_wraddr", WrAddr, 7);
        drive(1, 0, 0);
        Reset = 1'b1;
        #1;
        check("async_count", Count, 0);
        check("async_wraddr", WrAddr, 0);
        check("async_empty", Empty, 1);
        check("async_ae", AlmostEmpty, 1);
        check("async_udf", Underflow, 0);
        edge_step();
        Reset = 1'b0;
        drive(1, 0, 0);
        check("post_rst_wraddr", WrAddr, 0);
        check("post_rst_wracc", WrAccept, 1);
        edge_step();
        check("post_rst_count", Count, 1);
        drive(0, 1, 0);
        edge_step();
        check("drain_empty", Empty, 1);

        // Fill with 32 writes (pointers start at 1)
        for (int i = 1; i <= 32; i++) begin
            drive(1, 0, 0);
            edge_step();
            if (i == 4)  check("ae_at_4", AlmostEmpty, 1);
            if (i == 5)  check("ae_at_5", AlmostEmpty, 0);
            if (i == 27) check("af_at_27", AlmostFull, 0);
            if (i == 28) check("af_at_28", AlmostFull, 1);
            if (i == 31) check("full_at_31", Full, 0);
        end
        check("fill_full", Full, 1);
        check("fill_count", Count, 32);
        drive(1, 0, 0);
        check("ovf_wracc", WrAccept, 0);
        edge_step();
        check("ovf_flag", Overflow, 1);
        check("ovf_wraddr_held", WrAddr, 1);
        check("ovf_count", Count, 32);

        // Simultaneous at Full
        drive(1, 1, 0);
        check("full_rw_rdacc", RdAccept, 1);
        check("full_rw_wracc", WrAccept, 0);
        edge_step();
        check("full_rw_count", Count, 31);
        check("full_rw_full", Full, 0);
        check("full_rw_ovf", Overflow, 1);

        // Down to 20, then Clear with a write pending
        for (int i = 0; i < 11; i++) begin drive(0, 1, 0); edge_step(); end
        check("pre_clr_count", Count, 20);
        drive(1, 0, 1);
        check("clr_wracc", WrAccept, 0);
        edge_step();
        check("clr_count", Count, 0);
        check("clr_empty", Empty, 1);
        check("clr_ovf", Overflow, 0);
        check("clr_wraddr", WrAddr, 0);

        // Steady state at Count=3 across address wraps
        for (int i = 0; i < 3; i++) begin drive(1, 0, 0); edge_step(); end
        wraps = 0;
        prev_wr = WrAddr;
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 0);
            edge_step();
            if (prev_wr == 31 && WrAddr == 0) wraps++;
            prev_wr = WrAddr;
            check("steady_count", Count, 3);
            check("steady_trail", (WrAddr - RdAddr) & 31, 3);
        end
        check("steady_wraps", wraps, 3);
        check("steady_wraddr", WrAddr, 7);
        check("steady_full", Full, 0);
        check("steady_empty", Empty, 0);

        drive(0, 0, 0);
        edge_step();
        @(negedge Clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
